bus_sequencer: RTL and testbench

- Programmable stimulus source that drives the 6-bit inpBus of the Connector stage.
- Replaces the free-running testbench counter with a start/done-controlled engine.
- Generates vector sweeps of configurable length in one of four pattern modes, with a stall input.
- Sits directly upstream of Connector; the optional MISR also observes Connector's 5-bit outBus.

---
 rtl/seq_pkg.sv | 35 +++
 rtl/seq_misr.sv | 29 ++
 rtl/bus_sequencer.sv | 116 +++++++++++
 tb/tb_bus_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types, constants and pattern helpers for the bus sequencer.
// Pure declarations only: no state, no latency, no flow control.
package seq_pkg;

  localparam int SEQ_W = 6;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    WALK1 = 2'd1,
    LFSR  = 2'd2,
    GRAY  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // x^6+x^5+1 vector generator and x^5+x^3+1 response compactor
  localparam logic [SEQ_W-1:0] LFSR_SEED = 6'b000001;
  localparam int LFSR_TAP_HI = 5;
  localparam int LFSR_TAP_LO = 4;
  localparam int MISR_TAP_HI = 4;
  localparam int MISR_TAP_LO = 2;

  function automatic logic [SEQ_W-1:0] gray_of(input logic [SEQ_W-1:0] k);
    return k ^ (k >> 1);
  endfunction

  function automatic logic [SEQ_W-1:0] lfsr_next(input logic [SEQ_W-1:0] v);
    return {v[SEQ_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/seq_misr.sv
// Response signature register, present only when SEQ_MISR_EN is defined.
// Updates one cycle after each enabled sample; clear wins over enable; no backpressure.
`ifdef SEQ_MISR_EN
module seq_misr
  import seq_pkg::*;
#(
  parameter int RESP_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [RESP_W-1:0] outBus,
  output logic [RESP_W-1:0] signature
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= {signature[RESP_W-2:0],
                    signature[MISR_TAP_HI] ^ signature[MISR_TAP_LO]} ^ outBus;
    end
  end

endmodule
`endif

// File: rtl/bus_sequencer.sv
// Start/done-controlled vector sweep engine feeding Connector's inpBus; optional MISR via SEQ_MISR_EN.
// Vector 0 appears one cycle after start; hold stalls vector, index and remaining count in place.
module bus_sequencer
  import seq_pkg::*;
#(
  parameter int IN_W  = SEQ_W,
  parameter int LEN_W = 7
`ifdef SEQ_MISR_EN
  ,
  parameter int RESP_W = 5
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  len,
  input  logic              hold,
`ifdef SEQ_MISR_EN
  input  logic [RESP_W-1:0] outBus,
  output logic [RESP_W-1:0] signature,
`endif
  output logic [IN_W-1:0]   inpBus,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  // remaining count is "vectors still to come after the one on the bus"
  localparam logic [LEN_W-1:0] FULL_SWEEP_M1 = LEN_W'((2 ** IN_W) - 1);

  state_t            stateQ, stateNext;
  mode_t             modeQ;
  logic [IN_W-1:0]   idxQ, idxNext;
  logic [IN_W-1:0]   lfsrQ, lfsrNext;
  logic [LEN_W-1:0]  remQ;
  logic              startTake, advance;

  function automatic logic [IN_W-1:0] vecOf(input mode_t m,
                                             input logic [IN_W-1:0] k,
                                             input logic [IN_W-1:0] l);
    logic [IN_W-1:0] v;
    v = k;
    case (m)
      COUNT:   v = k;
      WALK1:   v = IN_W'(1) << (k % IN_W);
      LFSR:    v = l;
      default: v = gray_of(k);
    endcase
    return v;
  endfunction

  assign startTake = (stateQ == IDLE) && start;
  assign advance   = (stateQ == RUN) && !hold && (remQ != '0);
  assign idxNext   = idxQ + IN_W'(1);
  assign lfsrNext  = lfsr_next(lfsrQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (!hold && (remQ == '0)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    valid = (stateQ == RUN);
    busy  = (stateQ != IDLE);
    done  = (stateQ == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      modeQ  <= COUNT;
      idxQ   <= '0;
      lfsrQ  <= '0;
      remQ   <= '0;
      inpBus <= '0;
    end else if (startTake) begin
      modeQ  <= mode_t'(mode);
      idxQ   <= '0;
      lfsrQ  <= LFSR_SEED;
      remQ   <= (len == '0) ? FULL_SWEEP_M1 : len - LEN_W'(1);
      inpBus <= vecOf(mode_t'(mode), '0, LFSR_SEED);
    end else if (advance) begin
      idxQ   <= idxNext;
      lfsrQ  <= lfsrNext;
      remQ   <= remQ - LEN_W'(1);
      inpBus <= vecOf(modeQ, idxNext, lfsrNext);
    end
  end

`ifdef SEQ_MISR_EN
  seq_misr #(
    .RESP_W(RESP_W)
  ) uMisr (
    .clk      (clk),
    .reset    (reset),
    .clear    (startTake),
    .enable   ((stateQ == RUN) && !hold),
    .outBus   (outBus),
    .signature(signature)
  );
`endif

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: each sweep pattern, hold, len boundaries, mid-sweep reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [6:0] len = 7'd0;
  logic [5:0] inpBus;
  logic       valid, busy, done;
`ifdef SEQ_MISR_EN
  logic [4:0] outBus = 5'd0;
  logic [4:0] signature;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .len      (len),
    .hold     (hold),
`ifdef SEQ_MISR_EN
    .outBus   (outBus),
    .signature(signature),
`endif
    .inpBus   (inpBus),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic startSweep(input logic [1:0] m, input logic [6:0] l);
    start = 1'b1;
    mode  = m;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic checkVec(input string tag, input int expVec);
    checkEq({tag, "_vec"}, 32'(inpBus), expVec);
    checkEq({tag, "_valid"}, 32'(valid), 1);
  endtask

  // DONE cycle followed by the first IDLE cycle
  task automatic checkDone(input string tag, input int lastVec);
    checkEq({tag, "_done"}, 32'(done), 1);
    checkEq({tag, "_done_valid"}, 32'(valid), 0);
    checkEq({tag, "_done_busy"}, 32'(busy), 1);
    checkEq({tag, "_done_vec"}, 32'(inpBus), lastVec);
    step();
    checkEq({tag, "_idle_done"}, 32'(done), 0);
    checkEq({tag, "_idle_busy"}, 32'(busy), 0);
    checkEq({tag, "_idle_valid"}, 32'(valid), 0);
    checkEq({tag, "_idle_vec"}, 32'(inpBus), lastVec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  int walkExp [8] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                      6'b010000, 6'b100000, 6'b000001, 6'b000010};
  int grayExp [4] = '{6'b000000, 6'b000001, 6'b000011, 6'b000010};

  initial begin
    logic [5:0] model;
    int zeroSeen;
    int doneSeen;

    // reset state
    #12;
    checkEq("rst_vec", 32'(inpBus), 0);
    checkEq("rst_valid", 32'(valid), 0);
    checkEq("rst_busy", 32'(busy), 0);
    checkEq("rst_done", 32'(done), 0);
`ifdef SEQ_MISR_EN
    checkEq("rst_sig", 32'(signature), 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    step();
    checkEq("idle_busy", 32'(busy), 0);

    // COUNT, len=5
    startSweep(2'd0, 7'd5);
    checkEq("count_busy", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      checkVec("count", k);
      step();
    end
    checkDone("count", 4);

    // WALK1, len=8; start held and mode/len changed mid-sweep must be ignored
    start = 1'b1;
    mode  = 2'd1;
    len   = 7'd8;
    step();
    mode  = 2'd0;
    len   = 7'd3;
    for (int k = 0; k < 8; k++) begin
      checkVec("walk1", walkExp[k]);
      if (k == 5) start = 1'b0;
      step();
    end
    checkDone("walk1", 6'b000010);

    // LFSR, len=0 -> 64 vectors, period 63
    startSweep(2'd2, 7'd0);
    model = 6'b000001;
    zeroSeen = 0;
    for (int k = 0; k < 64; k++) begin
      checkVec("lfsr", int'(model));
      if (inpBus == 6'd0) zeroSeen++;
      if (k == 63) checkEq("lfsr_v63", 32'(inpBus), 6'b000001);
      model = {model[4:0], model[5] ^ model[4]};
      step();
    end
    checkEq("lfsr_nozero", zeroSeen, 0);
    checkDone("lfsr", 6'b000001);

    // GRAY, len=4 with vector 2 held for three extra cycles
    startSweep(2'd3, 7'd4);
    checkVec("gray0", grayExp[0]);
    step();
    checkVec("gray1", grayExp[1]);
    step();
    checkVec("gray2", grayExp[2]);
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      step();
      checkVec("gray_hold", grayExp[2]);
      checkEq("gray_hold_busy", 32'(busy), 1);
    end
    hold = 1'b0;
    step();
    checkVec("gray3", grayExp[3]);
    step();
    checkDone("gray", grayExp[3]);

    // len=1: single vector then DONE
    startSweep(2'd0, 7'd1);
    checkVec("len1", 0);
    step();
    checkDone("len1", 0);

    // COUNT, len=10, reset after vector 3
    startSweep(2'd0, 7'd10);
    for (int k = 0; k < 4; k++) begin
      checkVec("abort", k);
      if (k < 3) step();
    end
    #1;
    reset = 1'b0;
    #1;
    checkEq("abort_vec", 32'(inpBus), 0);
    checkEq("abort_valid", 32'(valid), 0);
    checkEq("abort_busy", 32'(busy), 0);
    doneSeen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) doneSeen++;
    end
    checkEq("abort_nodone", doneSeen, 0);
    reset = 1'b1;
    step();
    checkEq("abort_idle_done", 32'(done), 0);
    startSweep(2'd0, 7'd3);
    checkVec("restart0", 0);
    step();
    checkVec("restart1", 1);
    step();
    checkVec("restart2", 2);
    step();
    checkDone("restart", 2);

`ifdef SEQ_MISR_EN
    // signature over COUNT len=2 with responses 0x01, 0x02
    startSweep(2'd0, 7'd2);
    checkEq("misr_clear", 32'(signature), 0);
    outBus = 5'h01;
    step();
    checkEq("misr_s1", 32'(signature), 5'h01);
    outBus = 5'h02;
    step();
    checkEq("misr_s2", 32'(signature), 5'h00);
    checkEq("misr_done", 32'(done), 1);
    outBus = 5'h1F;
    step();
    checkEq("misr_hold", 32'(signature), 5'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
